reaction_test_controller: RTL and testbench

//  Upstream trial sequencer for the reaction-timer display path. Arms a trial on a start

---
 rtl/reaction_test_controller_pkg.sv | 22 ++
 rtl/reaction_test_controller_sync_edge.sv | 26 ++
 rtl/reaction_test_controller.sv | 164 ++++++++++++++++
 tb/tb_reaction_test_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reaction_test_controller_pkg.sv
// Shared definitions for the reaction-test trial sequencer.
//   state_t    : FSM encodings (3 bits)
//   LFSR_TAPS  : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   lfsr_step  : one right-shift Galois LFSR advance
package reaction_test_controller_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      LIT     = 3'd2,
      DONE    = 3'd3,
      FOUL    = 3'd4,
      TIMEOUT = 3'd5
   } state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/reaction_test_controller_sync_edge.sv
// Two-flop synchroniser with rising-edge detect on the synchronised level.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (clears the whole chain)
//   d_i    : asynchronous level input
//   lvl_o  : synchronised level
//   rise_o : one-cycle pulse on a 0->1 of lvl_o
module reaction_test_controller_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic lvl_o,
   output logic rise_o
);

   // [0],[1] form the synchroniser; [2] is the delayed copy for edge detect
   logic [2:0] sh_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) sh_q <= '0;
      else       sh_q <= {sh_q[1:0], d_i};
   end

   assign lvl_o  = sh_q[1];
   assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/reaction_test_controller.sv
// Reaction-timer trial sequencer. Arms on a start press, waits a fixed plus
// pseudo-random number of ticks, lights the LED (count enable downstream) and
// ends the trial when the reaction switch rises. Early switch = false start.
//   clk_100MHz      : system clock
//   clear           : synchronous active-high reset
//   start           : async start button (level)
//   reaction_switch : async reaction switch (level)
//   led_on          : stimulus LED / downstream count enable
//   timer_clear     : one-cycle pulse on the arm cycle
//   done            : valid result held
//   foul            : false start held
//   timeout         : no-reaction timeout held (0 unless REACTION_TIMEOUT_EN)
// Build option: define REACTION_TIMEOUT_EN to end LIT after TIMEOUT_MS ticks.
module reaction_test_controller
   import reaction_test_controller_pkg::*;
#(
   parameter int          CLK_HZ       = 100_000_000,
   parameter int          TICK_HZ      = 1000,
   parameter int          MIN_DELAY_MS = 1000,
   parameter int          RAND_BITS    = 12,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          TIMEOUT_MS   = 9999
) (
   input  logic clk_100MHz,
   input  logic clear,
   input  logic start,
   input  logic reaction_switch,
   output logic led_on,
   output logic timer_clear,
   output logic done,
   output logic foul,
   output logic timeout
);

   localparam int PRE_DIV = CLK_HZ / TICK_HZ;
   localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam int DLY_W   = $clog2(MIN_DELAY_MS + 2**RAND_BITS);

   logic st_s, start_rise, rs_s, unused_rs_rise;

   reaction_test_controller_sync_edge u_sync_start (
      .clk_i(clk_100MHz), .rst_i(clear), .d_i(start),
      .lvl_o(st_s), .rise_o(start_rise)
   );

   reaction_test_controller_sync_edge u_sync_react (
      .clk_i(clk_100MHz), .rst_i(clear), .d_i(reaction_switch),
      .lvl_o(rs_s), .rise_o(unused_rs_rise)
   );

   state_t             state_q;
   logic [PRE_W-1:0]   presc_q, presc_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [DLY_W-1:0]   dly_q;
   logic               led_q, done_q, foul_q;
   logic               tick, arm_ok, arm;

   assign tick   = (presc_q == PRE_W'(PRE_DIV - 1));
   assign lfsr_d = lfsr_step(lfsr_q);

   // A new trial may start only from a resting state, and only once the
   // switch has been lowered.
   always_comb begin
      arm_ok = (state_q == IDLE) || (state_q == DONE) || (state_q == FOUL);
`ifdef REACTION_TIMEOUT_EN
      arm_ok = arm_ok || (state_q == TIMEOUT);
`endif
   end
   assign arm = arm_ok & start_rise & ~rs_s;

   // Prescaler restarts on arm so the first delay tick is a full period away.
   always_comb begin
      if (arm || tick) presc_d = '0;
      else             presc_d = presc_q + PRE_W'(1);
   end

   always_ff @(posedge clk_100MHz) begin
      if (clear) begin
         presc_q <= '0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         presc_q <= presc_d;
         lfsr_q  <= lfsr_d;
      end
   end

`ifdef REACTION_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS + 1) : 1;
   logic [TO_W-1:0] to_q;
   logic            timeout_q;
   assign timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_MS != 0);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_100MHz) begin
      if (clear) begin
         state_q <= IDLE;
         dly_q   <= '0;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
         foul_q  <= 1'b0;
`ifdef REACTION_TIMEOUT_EN
         to_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else if (arm) begin
         state_q <= ARMED;
         dly_q   <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
         led_q   <= 1'b0;
         done_q  <= 1'b0;
         foul_q  <= 1'b0;
`ifdef REACTION_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ARMED: begin
               // Switch is checked first: a switch on the expiry tick is a foul.
               if (rs_s) begin
                  state_q <= FOUL;
                  foul_q  <= 1'b1;
               end else if (tick) begin
                  if (dly_q <= DLY_W'(1)) begin
                     state_q <= LIT;
                     led_q   <= 1'b1;
`ifdef REACTION_TIMEOUT_EN
                     to_q    <= '0;
`endif
                  end
                  if (dly_q != '0) dly_q <= dly_q - DLY_W'(1);
               end
            end
            LIT: begin
               if (rs_s) begin
                  state_q <= DONE;
                  led_q   <= 1'b0;
                  done_q  <= 1'b1;
               end
`ifdef REACTION_TIMEOUT_EN
               else if (tick) begin
                  if (to_q == TO_W'(TIMEOUT_MS - 1)) begin
                     state_q   <= TIMEOUT;
                     led_q     <= 1'b0;
                     timeout_q <= 1'b1;
                  end else begin
                     to_q <= to_q + TO_W'(1);
                  end
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign led_on      = led_q;
   assign timer_clear = arm;
   assign done        = done_q;
   assign foul        = foul_q;

endmodule

// File: tb/tb_reaction_test_controller.sv
// Directed bench for reaction_test_controller with 10 clocks per tick,
// MIN_DELAY_MS=5, RAND_BITS=3, seed 1, TIMEOUT_MS=4. A reference LFSR tracks
// the expected random delay; everything is sampled on the falling edge.
module tb_reaction_test_controller;

   logic clk = 1'b0;
   logic clear, start, reaction_switch;
   logic led_on, timer_clear, done, foul, timeout;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int arm_cyc;
   logic [15:0] arm_lf;
   logic [15:0] m_lfsr = 16'h0001;

   reaction_test_controller #(
      .CLK_HZ(1000), .TICK_HZ(100), .MIN_DELAY_MS(5), .RAND_BITS(3),
      .LFSR_SEED(16'h0001), .TIMEOUT_MS(4)
   ) dut (
      .clk_100MHz(clk), .clear(clear), .start(start),
      .reaction_switch(reaction_switch), .led_on(led_on),
      .timer_clear(timer_clear), .done(done), .foul(foul), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference Galois LFSR, x^16+x^14+x^13+x^11+1, right shift
   always @(posedge clk)
      m_lfsr <= clear ? 16'h0001 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Press start for 8 cycles, count timer_clear pulses, capture arm cycle/LFSR.
   task automatic do_arm(output int pulses);
      pulses = 0;
      start  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (timer_clear) begin
            if (pulses == 0) begin
               arm_cyc = cyc;
               arm_lf  = m_lfsr;
            end
            pulses++;
         end
      end
      start = 1'b0;
   endtask

   task automatic wait_led(output int rc);
      int n;
      n = 0;
      while (!led_on && n < 200) begin
         @(negedge clk);
         n++;
      end
      rc = cyc;
      check("led_rise_in_budget", {31'd0, led_on}, 32'd1);
   endtask

   // Arm-cycle sample is half a clock before the arm edge, hence the +1.
   function automatic int led_delay();
      return 10 * (5 + int'(arm_lf[2:0])) + 1;
   endfunction

   initial begin
      int p, rc, n, target;
      logic seen, all_on;

      // 1 reset
      clear = 1'b1; start = 1'b0; reaction_switch = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {27'd0, led_on, timer_clear, done, foul, timeout}, 32'd0);
      clear = 1'b0;
      @(negedge clk);
      check("idle_outputs", {27'd0, led_on, timer_clear, done, foul, timeout}, 32'd0);

      // 2 normal trial
      do_arm(p);
      check("normal_clear_pulses", p, 1);
      check("armed_led_off", {31'd0, led_on}, 0);
      wait_led(rc);
      check("normal_led_delay", rc - arm_cyc, led_delay());
      repeat (20) @(negedge clk);
      reaction_switch = 1'b1;
      @(negedge clk);
      check("led_held_during_sync", {31'd0, led_on}, 1);
      n = 0;
      while (led_on && n < 3) begin @(negedge clk); n++; end
      check("led_fall_after_react", {31'd0, led_on}, 0);
      check("done_set", {30'd0, done, foul}, 32'd2);

      // 3 false start
      reaction_switch = 1'b0;
      repeat (5) @(negedge clk);
      check("done_held", {31'd0, done}, 1);
      do_arm(p);
      check("fs_clear_pulses", p, 1);
      check("done_cleared_on_arm", {31'd0, done}, 0);
      while (cyc < arm_cyc + 15) @(negedge clk);
      reaction_switch = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin @(negedge clk); seen |= led_on; end
      check("fs_foul", {31'd0, foul}, 1);
      check("fs_led_never", {31'd0, seen}, 0);
      do_arm(p);
      check("start_with_switch_high_ignored", p, 0);
      check("foul_held", {31'd0, foul}, 1);
      reaction_switch = 1'b0;
      repeat (5) @(negedge clk);
      do_arm(p);
      check("rearm_pulses", p, 1);
      check("foul_cleared", {31'd0, foul}, 0);

      // 4 collision: rs_s first high in the expiry-tick cycle
      target = arm_cyc + led_delay() - 3;
      while (cyc < target) @(negedge clk);
      reaction_switch = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin @(negedge clk); seen |= led_on; end
      check("collision_foul", {30'd0, foul, done}, 32'd2);
      check("collision_led_never", {31'd0, seen}, 0);

      // 5 start ignored in ARMED and LIT, clear during LIT
      reaction_switch = 1'b0;
      repeat (5) @(negedge clk);
      do_arm(p);
      check("t5_arm_pulses", p, 1);
      do_arm(p);
      check("start_in_armed_ignored", p, 0);
      wait_led(rc);
      check("t5_led_delay_unchanged", rc - arm_cyc, led_delay());
      do_arm(p);
      check("start_in_lit_ignored", p, 0);
      check("lit_led_held", {31'd0, led_on}, 1);
      clear = 1'b1;
      @(negedge clk);
      check("clear_in_lit", {27'd0, led_on, timer_clear, done, foul, timeout}, 32'd0);
      clear = 1'b0;
      @(negedge clk);

      // 6 no reaction
      do_arm(p);
      check("t6_arm_pulses", p, 1);
      wait_led(rc);
      check("t6_led_delay", rc - arm_cyc, led_delay());
`ifdef REACTION_TIMEOUT_EN
      n = 1;
      for (int i = 0; i < 500 && led_on; i++) begin
         @(negedge clk);
         if (led_on) n++;
      end
      check("timeout_led_cycles", n, 40);
      check("timeout_flag", {29'd0, timeout, led_on, done}, 32'd4);
      do_arm(p);
      check("rearm_from_timeout", p, 1);
      check("timeout_cleared", {31'd0, timeout}, 0);
`else
      all_on = 1'b1;
      for (int i = 0; i < 500; i++) begin @(negedge clk); all_on &= led_on; end
      check("lit_waits_forever", {31'd0, all_on}, 1);
      check("timeout_tied_low", {31'd0, timeout}, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
